id_ex_stage: RTL and testbench

//  Decode/operand stage of the 5-stage MIPS pipeline, directly downstream of the register file.
//  - Drives the read addresses ra1/ra2 and captures rd1/rd2.
//  - Detects load-use hazards and inserts a bubble when one occurs.
//  - Registers the decoded operands into the ID/EX pipeline register consumed by EX.
//  - Handles stall, flush and valid tracking for that register.

---
 rtl/mips_pkg.sv | 66 ++++++
 rtl/id_ex_stage_if.sv | 12 +
 rtl/id_ex_stage_hazard_unit.sv | 19 +
 rtl/id_ex_stage.sv | 129 ++++++++++++
 tb/tb_id_ex_stage.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS ID stage: opcode encodings, the ID/EX
// pipeline register layout and the combinational instruction decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        regwr;
    logic        load;
    logic [31:0] pc4;
  } id_ex_t;

  typedef struct packed {
    logic [4:0] dst;
    logic       regwr;
    logic       load;
    logic       uses_rt;
  } decode_t;

  // Unknown opcodes fall through as NOPs; a write to $0 is never a write.
  function automatic decode_t decode(input logic [5:0] op,
                                     input logic [4:0] rt,
                                     input logic [4:0] rd);
    decode_t d;
    d = '0;
    case (op)
      OP_RTYPE: begin
        d.dst     = rd;
        d.regwr   = 1'b1;
        d.uses_rt = 1'b1;
      end
      OP_LW: begin
        d.dst   = rt;
        d.regwr = 1'b1;
        d.load  = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        d.dst   = rt;
        d.regwr = 1'b1;
      end
      OP_SW, OP_BEQ: d.uses_rt = 1'b1;
      default: ;
    endcase
    if (d.dst == 5'd0) d.regwr = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// IF/ID -> ID handshake: valid instruction word and its PC+4 from upstream,
// ready back from the ID stage (0 = IF/ID must hold).
//   master: IF/ID side (drives instruction), slave: ID stage.
interface id_ex_stage_if;
  logic        if_valid_i;
  logic [31:0] if_instr_i;
  logic [31:0] if_pc4_i;
  logic        id_ready_o;

  modport master (output if_valid_i, if_instr_i, if_pc4_i, input id_ready_o);
  modport slave  (input if_valid_i, if_instr_i, if_pc4_i, output id_ready_o);
endinterface

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use hazard detector: flags when the instruction in ID reads the
// destination of a load currently sitting in ID/EX.
//   rs, rt, uses_rt  : source registers of the ID instruction
//   if_valid         : ID instruction valid
//   ex_valid, ex_load, ex_dst : state of the ID/EX entry
//   luh              : hazard, insert one bubble
module hazard_unit (
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rt,
  input  logic       if_valid,
  input  logic       ex_valid,
  input  logic       ex_load,
  input  logic [4:0] ex_dst,
  output logic       luh
);
  assign luh = if_valid & ex_valid & ex_load & (ex_dst != 5'd0)
             & ((ex_dst == rs) | (uses_rt & (ex_dst == rt)));
endmodule

// File: rtl/id_ex_stage.sv
// MIPS decode/operand stage: reads the register file, decodes the IF/ID
// instruction, inserts load-use bubbles and owns the ID/EX register.
//   clk, rst_n        : clock, synchronous active-low reset
//   ifid (slave)      : IF/ID valid/instr/pc4 in, id_ready_o out
//   ra1_o/ra2_o, rd1_i/rd2_i : register file read ports
//   wb_we_i/wa/wd     : writeback port (used for the optional bypass)
//   ex_stall_i, flush_i : hold / kill the ID/EX entry
//   ex_*_o            : ID/EX register fields
//   bubble_cnt_o      : saturating count of load-use bubbles
// Optional feature macro: WB_BYPASS_EN forwards a same-cycle WB write to
// the operand capture.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_stage_if.slave     ifid,
  output logic [4:0]       ra1_o,
  output logic [4:0]       ra2_o,
  input  logic [31:0]      rd1_i,
  input  logic [31:0]      rd2_i,
  input  logic             wb_we_i,
  input  logic [4:0]       wb_wa_i,
  input  logic [31:0]      wb_wd_i,
  input  logic             ex_stall_i,
  input  logic             flush_i,
  output logic             ex_valid_o,
  output logic [5:0]       ex_op_o,
  output logic [5:0]       ex_funct_o,
  output logic [4:0]       ex_rs_o,
  output logic [4:0]       ex_rt_o,
  output logic [4:0]       ex_dst_o,
  output logic [31:0]      ex_a_o,
  output logic [31:0]      ex_b_o,
  output logic [31:0]      ex_imm_o,
  output logic             ex_regwr_o,
  output logic             ex_load_o,
  output logic [31:0]      ex_pc4_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  id_ex_t     r;
  id_ex_t     nxt;
  decode_t    dec;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       luh;
  logic [31:0] opa;
  logic [31:0] opb;

  assign rs    = ifid.if_instr_i[25:21];
  assign rt    = ifid.if_instr_i[20:16];
  assign ra1_o = rs;
  assign ra2_o = rt;
  assign dec   = decode(ifid.if_instr_i[31:26], rt, ifid.if_instr_i[15:11]);

`ifdef WB_BYPASS_EN
  // The regfile commits on the same edge that captures ID/EX, so its read
  // port still shows the old value; take the WB data directly instead.
  assign opa = (wb_we_i && wb_wa_i != 5'd0 && wb_wa_i == rs) ? wb_wd_i : rd1_i;
  assign opb = (wb_we_i && wb_wa_i != 5'd0 && wb_wa_i == rt) ? wb_wd_i : rd2_i;
`else
  logic wb_unused;
  assign wb_unused = ^{wb_we_i, wb_wa_i, wb_wd_i};
  assign opa = rd1_i;
  assign opb = rd2_i;
`endif

  hazard_unit u_hazard (
    .rs       (rs),
    .rt       (rt),
    .uses_rt  (dec.uses_rt),
    .if_valid (ifid.if_valid_i),
    .ex_valid (r.valid),
    .ex_load  (r.load),
    .ex_dst   (r.dst),
    .luh      (luh)
  );

  assign ifid.id_ready_o = ~ex_stall_i & ~luh;

  always_comb begin
    nxt       = '0;
    nxt.valid = ifid.if_valid_i;
    nxt.op    = ifid.if_instr_i[31:26];
    nxt.funct = ifid.if_instr_i[5:0];
    nxt.rs    = rs;
    nxt.rt    = rt;
    nxt.dst   = dec.dst;
    nxt.a     = opa;
    nxt.b     = opb;
    nxt.imm   = {{16{ifid.if_instr_i[15]}}, ifid.if_instr_i[15:0]};
    nxt.regwr = dec.regwr;
    nxt.load  = dec.load;
    nxt.pc4   = ifid.if_pc4_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r            <= '0;
      bubble_cnt_o <= '0;
    end else if (flush_i) begin
      r.valid <= 1'b0;
    end else if (ex_stall_i) begin
      r <= r;
    end else if (luh) begin
      r.valid <= 1'b0;
      if (bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
    end else begin
      r <= nxt;
    end
  end

  assign ex_valid_o = r.valid;
  assign ex_op_o    = r.op;
  assign ex_funct_o = r.funct;
  assign ex_rs_o    = r.rs;
  assign ex_rt_o    = r.rt;
  assign ex_dst_o   = r.dst;
  assign ex_a_o     = r.a;
  assign ex_b_o     = r.b;
  assign ex_imm_o   = r.imm;
  assign ex_regwr_o = r.regwr;
  assign ex_load_o  = r.load;
  assign ex_pc4_o   = r.pc4;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage. A second instance with CNT_W=2
// shares the stimulus to exercise bubble-counter saturation.
module tb_id_ex_stage;
  localparam logic [31:0] I_ADDI  = 32'h2043FFFB; // addi $3,$2,-5
  localparam logic [31:0] I_LW4   = 32'h8C240000; // lw   $4,0($1)
  localparam logic [31:0] I_ADD   = 32'h00822820; // add  $5,$4,$2
  localparam logic [31:0] I_SW4   = 32'hAC240000; // sw   $4,0($1)
  localparam logic [31:0] I_ADDI4 = 32'h20240005; // addi $4,$1,5
  localparam logic [31:0] I_LW0   = 32'h8C200000; // lw   $0,0($1)
  localparam logic [31:0] I_ADD00 = 32'h00002820; // add  $5,$0,$0

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] rd1, rd2, wb_wd;
  logic        wb_we, ex_stall, flush;
  logic [4:0]  wb_wa;

  logic [4:0]  ra1, ra2;
  logic        ex_valid, ex_regwr, ex_load;
  logic [5:0]  ex_op, ex_funct;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [31:0] ex_a, ex_b, ex_imm, ex_pc4;
  logic [15:0] cnt;

  logic [4:0]  s_ra1, s_ra2;
  logic        s_valid, s_regwr, s_load;
  logic [5:0]  s_op, s_funct;
  logic [4:0]  s_rs, s_rt, s_dst;
  logic [31:0] s_a, s_b, s_imm, s_pc4;
  logic [1:0]  s_cnt;

  id_ex_stage_if bus ();
  id_ex_stage_if bus_s ();
  assign bus_s.if_valid_i = bus.if_valid_i;
  assign bus_s.if_instr_i = bus.if_instr_i;
  assign bus_s.if_pc4_i   = bus.if_pc4_i;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .ifid(bus.slave), .ra1_o(ra1), .ra2_o(ra2),
    .rd1_i(rd1), .rd2_i(rd2), .wb_we_i(wb_we), .wb_wa_i(wb_wa), .wb_wd_i(wb_wd),
    .ex_stall_i(ex_stall), .flush_i(flush), .ex_valid_o(ex_valid),
    .ex_op_o(ex_op), .ex_funct_o(ex_funct), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt),
    .ex_dst_o(ex_dst), .ex_a_o(ex_a), .ex_b_o(ex_b), .ex_imm_o(ex_imm),
    .ex_regwr_o(ex_regwr), .ex_load_o(ex_load), .ex_pc4_o(ex_pc4),
    .bubble_cnt_o(cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .ifid(bus_s.slave), .ra1_o(s_ra1), .ra2_o(s_ra2),
    .rd1_i(rd1), .rd2_i(rd2), .wb_we_i(wb_we), .wb_wa_i(wb_wa), .wb_wd_i(wb_wd),
    .ex_stall_i(ex_stall), .flush_i(flush), .ex_valid_o(s_valid),
    .ex_op_o(s_op), .ex_funct_o(s_funct), .ex_rs_o(s_rs), .ex_rt_o(s_rt),
    .ex_dst_o(s_dst), .ex_a_o(s_a), .ex_b_o(s_b), .ex_imm_o(s_imm),
    .ex_regwr_o(s_regwr), .ex_load_o(s_load), .ex_pc4_o(s_pc4),
    .bubble_cnt_o(s_cnt)
  );

  int unsigned n_vec, n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc4,
                         input logic [31:0] a, input logic [31:0] b);
    bus.if_valid_i = 1'b1;
    bus.if_instr_i = instr;
    bus.if_pc4_i   = pc4;
    rd1 = a;
    rd2 = b;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    // reset with random inputs (no stall so ready reflects luh only)
    rst_n = 1'b0;
    bus.if_valid_i = 1'($urandom);
    bus.if_instr_i = $urandom;
    bus.if_pc4_i   = $urandom;
    rd1 = $urandom; rd2 = $urandom;
    wb_we = 1'($urandom); wb_wa = 5'($urandom); wb_wd = $urandom;
    flush = 1'($urandom); ex_stall = 1'b0;
    step(); step();
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_cnt",   32'(cnt), 32'd0);
    chk("rst_cnt_s", 32'(s_cnt), 32'd0);
    chk("rst_a",     ex_a, 32'd0);
    chk("rst_dst",   32'(ex_dst), 32'd0);
    chk("rst_rdy",   32'(bus.id_ready_o), 32'd1);

    rst_n = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_wa = 5'd0; wb_wd = 32'd0;

    // pass-through
    present(I_ADDI, 32'h104, 32'd10, 32'd77);
    chk("ra1", 32'(ra1), 32'd2);
    chk("ra2", 32'(ra2), 32'd3);
    chk("addi_rdy", 32'(bus.id_ready_o), 32'd1);
    step();
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_a",     ex_a, 32'd10);
    chk("addi_b",     ex_b, 32'd77);
    chk("addi_imm",   ex_imm, 32'hFFFFFFFB);
    chk("addi_dst",   32'(ex_dst), 32'd3);
    chk("addi_regwr", 32'(ex_regwr), 32'd1);
    chk("addi_op",    32'(ex_op), 32'h08);
    chk("addi_pc4",   ex_pc4, 32'h104);

    // load-use via rs
    present(I_LW4, 32'h108, 32'd5, 32'd0);
    step();
    chk("lw_load", 32'(ex_load), 32'd1);
    chk("lw_dst",  32'(ex_dst), 32'd4);
    present(I_ADD, 32'h10C, 32'd1, 32'd2);
    chk("lu_rdy", 32'(bus.id_ready_o), 32'd0);
    step();
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_cnt",    32'(cnt), 32'd1);
    chk("lu_cnt_s",  32'(s_cnt), 32'd1);
    chk("lu_rdy2",   32'(bus.id_ready_o), 32'd1);
    step();
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_dst",   32'(ex_dst), 32'd5);
    chk("add_funct", 32'(ex_funct), 32'h20);
    chk("add_pc4",   ex_pc4, 32'h10C);

    // load-use via rt (sw uses rt)
    present(I_LW4, 32'h110, 32'd0, 32'd0);
    step();
    present(I_SW4, 32'h114, 32'd0, 32'd0);
    chk("sw_rdy", 32'(bus.id_ready_o), 32'd0);
    step();
    chk("sw_cnt", 32'(cnt), 32'd2);
    step();
    chk("sw_valid", 32'(ex_valid), 32'd1);
    chk("sw_regwr", 32'(ex_regwr), 32'd0);

    // addi writes rt but does not read it: no bubble
    present(I_LW4, 32'h118, 32'd0, 32'd0);
    step();
    present(I_ADDI4, 32'h11C, 32'd0, 32'd0);
    chk("noru_rdy", 32'(bus.id_ready_o), 32'd1);
    step();
    chk("noru_valid", 32'(ex_valid), 32'd1);
    chk("noru_cnt",   32'(cnt), 32'd2);
    chk("noru_imm",   ex_imm, 32'd5);

    // flush beats stall; other fields unchanged
    ex_stall = 1'b1; flush = 1'b1;
    present(I_ADDI, 32'h120, 32'd9, 32'd9);
    chk("stall_rdy", 32'(bus.id_ready_o), 32'd0);
    step();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_dst",   32'(ex_dst), 32'd4);
    ex_stall = 1'b0; flush = 1'b0;

    // stall holds every field
    present(I_ADDI, 32'h124, 32'd10, 32'd77);
    step();
    ex_stall = 1'b1;
    present(I_ADD, 32'h128, 32'd99, 32'd98);
    step();
    chk("hold_valid", 32'(ex_valid), 32'd1);
    chk("hold_a",     ex_a, 32'd10);
    chk("hold_dst",   32'(ex_dst), 32'd3);
    chk("hold_pc4",   ex_pc4, 32'h124);
    chk("hold_op",    32'(ex_op), 32'h08);
    ex_stall = 1'b0;

    // WB bypass on rs only
    wb_we = 1'b1; wb_wa = 5'd2; wb_wd = 32'h1234;
    present(I_ADDI, 32'h12C, 32'd0, 32'd55);
    step();
`ifdef WB_BYPASS_EN
    chk("byp_a", ex_a, 32'h1234);
`else
    chk("byp_a", ex_a, 32'd0);
`endif
    chk("byp_b", ex_b, 32'd55);
    wb_we = 1'b0; wb_wa = 5'd0; wb_wd = 32'd0;

    // lw $0 never causes a bubble
    present(I_LW0, 32'h130, 32'd0, 32'd0);
    step();
    chk("lw0_load",  32'(ex_load), 32'd1);
    chk("lw0_regwr", 32'(ex_regwr), 32'd0);
    present(I_ADD00, 32'h134, 32'd0, 32'd0);
    chk("r0_rdy", 32'(bus.id_ready_o), 32'd1);
    step();
    chk("r0_valid", 32'(ex_valid), 32'd1);
    chk("r0_cnt",   32'(cnt), 32'd2);

    // three more load-use events: total 5, 2-bit counter saturates at 3
    for (int i = 0; i < 3; i++) begin
      present(I_LW4, 32'h200, 32'd0, 32'd0);
      step();
      present(I_ADD, 32'h204, 32'd0, 32'd0);
      step();
      step();
    end
    chk("sat_cnt",   32'(cnt), 32'd5);
    chk("sat_cnt_s", 32'(s_cnt), 32'd3);

    // reset while stalled on a hazard
    present(I_LW4, 32'h300, 32'd0, 32'd0);
    step();
    present(I_ADD, 32'h304, 32'd0, 32'd0);
    ex_stall = 1'b1; rst_n = 1'b0;
    step();
    chk("mrst_cnt",   32'(cnt), 32'd0);
    chk("mrst_cnt_s", 32'(s_cnt), 32'd0);
    chk("mrst_valid", 32'(ex_valid), 32'd0);
    rst_n = 1'b1; ex_stall = 1'b0;
    #1;
    chk("mrst_rdy", 32'(bus.id_ready_o), 32'd1);
    step();
    chk("mrst_add_valid", 32'(ex_valid), 32'd1);
    chk("mrst_add_dst",   32'(ex_dst), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
